// File: rtl/l15_req_arbiter_pkg.sv
// Shared definitions for the L1.5 request arbiter in the tile adapter:
// request-source port map, port id type and arbiter FSM states.
package l15_req_arbiter_pkg;

  localparam int NUM_PORTS_ADAPTER = 6;
  localparam int PORT_ID_W         = $clog2(NUM_PORTS_ADAPTER);

  typedef logic [PORT_ID_W-1:0] req_portid_t;

  localparam req_portid_t ICACHE    = req_portid_t'(0);
  localparam req_portid_t DCACHE    = req_portid_t'(1);
  localparam req_portid_t WBUF      = req_portid_t'(2);
  localparam req_portid_t UNC_READ  = req_portid_t'(3);
  localparam req_portid_t UNC_WRITE = req_portid_t'(4);
  localparam req_portid_t AMO       = req_portid_t'(5);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } l15_arb_state_e;

endpackage

// File: rtl/l15_req_arbiter_prio_pick.sv
// Lowest-index-wins picker: one-hot grant, binary index and any-request flag.
module l15_arb_prio_pick #(
  parameter int NumPorts = 6
) (
  input  logic [NumPorts-1:0]         req_i,
  output logic [NumPorts-1:0]         onehot_o,
  output logic [$clog2(NumPorts)-1:0] idx_o,
  output logic                        any_o
);

  localparam int IdxW = $clog2(NumPorts);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    // Scanning downward lets the lowest set index overwrite the rest.
    for (int i = NumPorts - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        idx_o       = IdxW'(i);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/l15_req_arbiter.sv
// Fixed-priority L1.5 request arbiter with aging boost and per-port
// outstanding-transaction limits released by tagged L1.5 returns.
module l15_req_arbiter
  import l15_req_arbiter_pkg::*;
#(
  parameter int NumPorts       = 6,
  parameter int PayloadWidth   = 128,
  parameter int AgeThreshold   = 16,
  parameter int MaxOutstanding = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumPorts-1:0]              req_valid_i,
  input  logic [NumPorts*PayloadWidth-1:0] req_payload_i,
  output logic [NumPorts-1:0]              req_ready_o,
  output logic                             l15_val_o,
  output logic [PayloadWidth-1:0]          l15_payload_o,
  output logic [$clog2(NumPorts)-1:0]      l15_portid_o,
  input  logic                             l15_header_ack_i,
  input  logic                             rtrn_valid_i,
  input  logic [$clog2(NumPorts)-1:0]      rtrn_portid_i,
  output logic                             busy_o,
  output logic                             err_o
);

  localparam int IdW  = $clog2(NumPorts);
  localparam int AgeW = $clog2(AgeThreshold + 1);
  localparam int OstW = $clog2(MaxOutstanding + 1);

  localparam logic [AgeW-1:0] AGE_MAX   = AgeW'(AgeThreshold);
  localparam logic [OstW-1:0] OST_MAX   = OstW'(MaxOutstanding);
  localparam logic [IdW:0]    PORTS_LIM = (IdW + 1)'(NumPorts);

  l15_arb_state_e                 state_q, state_d;
  logic [NumPorts-1:0][AgeW-1:0]  age_q, age_d;
  logic [NumPorts-1:0][OstW-1:0]  ost_q, ost_d;
  logic [PayloadWidth-1:0]        payload_q, payload_d;
  logic [IdW-1:0]                 portid_q, portid_d;
  logic                           err_q, err_d;

  logic [NumPorts-1:0] eligible, urgent, rtrn_hit;
  logic [NumPorts-1:0] urg_oh, elig_oh, win_oh;
  logic [IdW-1:0]      urg_idx, elig_idx, win_idx;
  logic                urg_any, elig_any;
  logic                accept;

  always_comb begin
    eligible = '0;
    urgent   = '0;
    rtrn_hit = '0;
    for (int p = 0; p < NumPorts; p++) begin
      eligible[p] = req_valid_i[p] && (ost_q[p] < OST_MAX);
      urgent[p]   = eligible[p] && (age_q[p] == AGE_MAX);
      rtrn_hit[p] = rtrn_valid_i && (rtrn_portid_i == p[IdW-1:0]);
    end
  end

  l15_arb_prio_pick #(.NumPorts(NumPorts)) u_pick_urgent (
    .req_i    (urgent),
    .onehot_o (urg_oh),
    .idx_o    (urg_idx),
    .any_o    (urg_any)
  );

  l15_arb_prio_pick #(.NumPorts(NumPorts)) u_pick_eligible (
    .req_i    (eligible),
    .onehot_o (elig_oh),
    .idx_o    (elig_idx),
    .any_o    (elig_any)
  );

  assign win_oh  = urg_any ? urg_oh  : elig_oh;
  assign win_idx = urg_any ? urg_idx : elig_idx;

  // Reset gates the combinational accept so req_ready_o is 0 throughout reset.
  assign accept = rst_ni && elig_any && ((state_q == IDLE) || l15_header_ack_i);

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = HOLD;
      HOLD:    if (l15_header_ack_i && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: captured request, aging and outstanding bookkeeping
  always_comb begin
    payload_d = payload_q;
    portid_d  = portid_q;
    age_d     = age_q;
    ost_d     = ost_q;
    err_d     = err_q;

    if (accept) begin
      portid_d = win_idx;
      for (int p = 0; p < NumPorts; p++) begin
        if (win_oh[p]) payload_d = req_payload_i[p*PayloadWidth +: PayloadWidth];
      end
    end

    for (int p = 0; p < NumPorts; p++) begin
      if (!req_valid_i[p] || (accept && win_oh[p])) begin
        age_d[p] = '0;
      end else if (accept && eligible[p] && (age_q[p] != AGE_MAX)) begin
        age_d[p] = age_q[p] + 1'b1;
      end

      // A same-cycle grant and return on one port cancel out.
      if (accept && win_oh[p] && !(rtrn_hit[p] && (ost_q[p] != '0))) begin
        ost_d[p] = ost_q[p] + 1'b1;
      end else if (!(accept && win_oh[p]) && rtrn_hit[p] && (ost_q[p] != '0)) begin
        ost_d[p] = ost_q[p] - 1'b1;
      end

      if (rtrn_hit[p] && (ost_q[p] == '0)) err_d = 1'b1;
    end

    if (rtrn_valid_i && ({1'b0, rtrn_portid_i} >= PORTS_LIM)) err_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only; combinational
  // blocks above use blocking assignments.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      age_q     <= '0;
      ost_q     <= '0;
      payload_q <= '0;
      portid_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      age_q     <= age_d;
      ost_q     <= ost_d;
      payload_q <= payload_d;
      portid_q  <= portid_d;
      err_q     <= err_d;
    end
  end

  // FSM: outputs
  always_comb begin
    l15_val_o   = (state_q == HOLD);
    req_ready_o = accept ? win_oh : '0;
    busy_o      = (state_q == HOLD) || (|ost_q);
  end

  assign l15_payload_o = payload_q;
  assign l15_portid_o  = portid_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_l15_req_arbiter.sv
// Self-checking bench for l15_req_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a behavioural reference model.
module tb_l15_req_arbiter;

  localparam int NP = 6;
  localparam int PW = 128;
  localparam int AT = 16;
  localparam int MO = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     v;
  logic [PW-1:0]     pay [NP];
  logic [NP*PW-1:0]  pay_flat;
  logic              ack, rv;
  logic [2:0]        rid;

  logic [NP-1:0]     ready;
  logic              val;
  logic [PW-1:0]     l15_pay;
  logic [2:0]        l15_id;
  logic              busy, err;

  always #5 clk = ~clk;

  always_comb begin
    pay_flat = '0;
    for (int p = 0; p < NP; p++) pay_flat[p*PW +: PW] = pay[p];
  end

  l15_req_arbiter #(
    .NumPorts(NP), .PayloadWidth(PW), .AgeThreshold(AT), .MaxOutstanding(MO)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_valid_i      (v),
    .req_payload_i    (pay_flat),
    .req_ready_o      (ready),
    .l15_val_o        (val),
    .l15_payload_o    (l15_pay),
    .l15_portid_o     (l15_id),
    .l15_header_ack_i (ack),
    .rtrn_valid_i     (rv),
    .rtrn_portid_i    (rid),
    .busy_o           (busy),
    .err_o            (err)
  );

  // Reference model state
  int            m_age [NP];
  int            m_ost [NP];
  bit            m_hold;
  logic [PW-1:0] m_pay;
  int            m_id;
  bit            m_err;

  int            errors = 0;
  int            checks = 0;
  int            last_grant;
  int            val_seen;
  logic [NP-1:0] keep;
  bit            auto_ret0;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_age[p] = 0;
      m_ost[p] = 0;
    end
    m_hold = 0;
    m_pay  = '0;
    m_id   = 0;
    m_err  = 0;
  endtask

  // One clock: check outputs mid-cycle, advance the model at the edge, then
  // let the requesters react to the grant.
  task automatic cycle();
    int            w;
    bit            can;
    bit            elig [NP];
    bit            any_ost;
    logic [NP-1:0] exp_ready;
    int            old_ost [NP];

    @(negedge clk);
    can = !m_hold || ack;
    w   = -1;
    for (int p = 0; p < NP; p++) elig[p] = v[p] && (m_ost[p] < MO);
    for (int p = NP - 1; p >= 0; p--) if (elig[p]) w = p;
    for (int p = NP - 1; p >= 0; p--) if (elig[p] && m_age[p] == AT) w = p;
    exp_ready = '0;
    if (can && w >= 0) exp_ready[w] = 1'b1;
    any_ost = 0;
    for (int p = 0; p < NP; p++) if (m_ost[p] != 0) any_ost = 1;

    check("req_ready", PW'(ready), PW'(exp_ready));
    check("l15_val", PW'(val), PW'(m_hold));
    if (m_hold) begin
      check("l15_portid", PW'(l15_id), PW'(m_id));
      check("l15_payload", l15_pay, m_pay);
    end
    check("busy", PW'(busy), PW'(m_hold || any_ost));
    check("err", PW'(err), PW'(m_err));
    if (val) val_seen++;

    @(posedge clk);
    last_grant = (can && w >= 0) ? w : -1;
    old_ost = m_ost;
    if (rv) begin
      if (rid >= NP) m_err = 1;
      else if (old_ost[rid] == 0) m_err = 1;
      else m_ost[rid]--;
    end
    if (last_grant >= 0) m_ost[last_grant]++;
    for (int p = 0; p < NP; p++) begin
      if (!v[p] || p == last_grant) m_age[p] = 0;
      else if (last_grant >= 0 && elig[p] && m_age[p] < AT) m_age[p]++;
    end
    if (last_grant >= 0) begin
      m_hold = 1;
      m_pay  = pay[last_grant];
      m_id   = last_grant;
    end else if (m_hold && ack) begin
      m_hold = 0;
    end

    #1;
    if (last_grant >= 0 && !keep[last_grant]) v[last_grant] = 1'b0;
    if (auto_ret0) begin
      rv  = (m_ost[0] > 0);
      rid = 3'd0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    v = '1; ack = 0; rv = 0; rid = '0; keep = '0; auto_ret0 = 0;
    model_reset();
    @(posedge clk); #1;
    check("rst_ready", PW'(ready), '0);
    check("rst_val", PW'(val), '0);
    check("rst_payload", l15_pay, '0);
    check("rst_portid", PW'(l15_id), '0);
    check("rst_busy", PW'(busy), '0);
    check("rst_err", PW'(err), '0);
    v = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    val_seen = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, pos, after, g1, g2, r;
    for (int p = 0; p < NP; p++) pay[p] = {4{32'hA000_0000 + 32'(p)}};

    // Single request, ack after three held cycles
    do_reset();
    v = 6'b000100;
    cycle();
    check("s1_grant", PW'(last_grant), PW'(2));
    repeat (3) cycle();
    ack = 1;
    cycle();
    ack = 0;
    repeat (2) cycle();
    check("s1_val_cycles", PW'(val_seen), PW'(4));

    // Priority and back-to-back issue
    do_reset();
    v = 6'b100001; ack = 1;
    cycle(); g1 = last_grant;
    cycle(); g2 = last_grant;
    repeat (2) cycle();
    check("s2_first", PW'(g1), PW'(0));
    check("s2_second", PW'(g2), PW'(5));
    check("s2_val_cycles", PW'(val_seen), PW'(2));

    // Starvation relief through aging
    do_reset();
    v = 6'b010001; keep = 6'b000001; ack = 1; auto_ret0 = 1;
    n = 0; pos = -1; after = -1;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (last_grant >= 0) begin
        n++;
        if (last_grant == 4 && pos < 0) pos = n;
        else if (pos > 0 && after < 0) after = last_grant;
      end
    end
    check("s3_aged_accept", PW'(pos), PW'(17));
    check("s3_resume", PW'(after), PW'(0));

    // Outstanding limit on port 1
    do_reset();
    v = 6'b000010; keep = 6'b000010; ack = 1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (last_grant == 1) n++;
    end
    check("s4_grants", PW'(n), PW'(MO));
    rv = 1; rid = 3'd1;
    n = 0;
    cycle();
    if (last_grant == 1) n++;
    rv = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (last_grant == 1) n++;
    end
    check("s4_release", PW'(n), PW'(1));

    // Return and blocked grant on port 3 at the limit
    do_reset();
    v = 6'b001000; keep = 6'b001000; ack = 1;
    repeat (6) cycle();
    rv = 1; rid = 3'd3;
    cycle();
    check("s5_refused", PW'(last_grant), PW'(-1));
    rv = 0;
    cycle();
    check("s5_regrant", PW'(last_grant), PW'(3));
    repeat (2) cycle();

    // Asynchronous reset while holding, then a spurious return
    do_reset();
    v = 6'b000100;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_async_val", PW'(val), '0);
    check("s6_async_busy", PW'(busy), '0);
    model_reset();
    v = '0; keep = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rv = 1; rid = 3'd2;
    cycle();
    rv = 0;
    repeat (3) cycle();
    check("s6_err_sticky", PW'(err), PW'(1));

    // Out-of-range return id
    do_reset();
    rv = 1; rid = 3'd7;
    cycle();
    rv = 0;
    cycle();
    check("s7_bad_id_err", PW'(err), PW'(1));

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < NP; p++) begin
        if (!v[p] && $urandom_range(0, 2) == 0) begin
          v[p]   = 1'b1;
          pay[p] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      ack = 1'($urandom_range(0, 1));
      r = $urandom_range(0, NP - 1);
      if (m_ost[r] > 0 && $urandom_range(0, 2) == 0) begin
        rv  = 1;
        rid = 3'(r);
      end else begin
        rv = 0;
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
